// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter, mode-gated edge pulse and sticky flag.
// Optional per-channel saturating edge counters are built when EDGE_DETECT_COUNT_EN is defined.
module edge_detect_multi #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2,
  parameter bit RESET_LEVEL = 1'b1,
  parameter int COUNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         d_in,
  input  logic [2*NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]         clr_flags,
  output logic [NUM_CH-1:0]         d_level,
  output logic [NUM_CH-1:0]         d_edge,
  output logic [NUM_CH-1:0]         edge_flag,
  output logic                      any_edge,
  output logic [NUM_CH*COUNT_W-1:0] edge_count
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
  logic [CNT_W-1:0]       filt_q [NUM_CH];
  logic [CNT_W-1:0]       filt_d [NUM_CH];
  logic [NUM_CH-1:0]      level_q, level_d;
  logic [NUM_CH-1:0]      edge_q, edge_d;
  logic [NUM_CH-1:0]      flag_q, flag_d;
  logic                   any_q;

  // Next-state for synchroniser, filter, level, edge pulse and sticky flag.
  always_comb begin
    level_d = level_q;
    edge_d  = '0;
    flag_d  = flag_q;
    for (int i = 0; i < NUM_CH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], d_in[i]};
      filt_d[i] = '0;
      if (sync_q[i][SYNC_STAGES-1] == level_q[i]) begin
        filt_d[i] = '0;
      end else if (filt_q[i] == FILT_LAST) begin
        // Level accepted: the direction picks which mode bit gates the pulse.
        level_d[i] = ~level_q[i];
        filt_d[i]  = '0;
        edge_d[i]  = level_q[i] ? mode[2*i+1] : mode[2*i];
      end else begin
        filt_d[i] = filt_q[i] + CNT_W'(1);
      end
      flag_d[i] = edge_d[i] | (flag_q[i] & ~clr_flags[i]);
    end
  end

  // State registers; reset loads the idle level and drops any filter count in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= {SYNC_STAGES{RESET_LEVEL}};
        filt_q[i] <= '0;
      end
      level_q <= {NUM_CH{RESET_LEVEL}};
      edge_q  <= '0;
      flag_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= sync_d[i];
        filt_q[i] <= filt_d[i];
      end
      level_q <= level_d;
      edge_q  <= edge_d;
      flag_q  <= flag_d;
      any_q   <= |edge_d;
    end
  end

  assign d_level   = level_q;
  assign d_edge    = edge_q;
  assign edge_flag = flag_q;
  assign any_edge  = any_q;

`ifdef EDGE_DETECT_COUNT_EN
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  logic [NUM_CH*COUNT_W-1:0] count_q, count_d;

  // Saturating counters; a clear coinciding with an edge leaves a count of one.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clr_flags[i]) begin
        count_d[i*COUNT_W +: COUNT_W] = edge_d[i] ? COUNT_W'(1) : {COUNT_W{1'b0}};
      end else if (edge_d[i] && (count_q[i*COUNT_W +: COUNT_W] != COUNT_MAX)) begin
        count_d[i*COUNT_W +: COUNT_W] = count_q[i*COUNT_W +: COUNT_W] + COUNT_W'(1);
      end else begin
        count_d[i*COUNT_W +: COUNT_W] = count_q[i*COUNT_W +: COUNT_W];
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign edge_count = count_q;
`else
  assign edge_count = '0;
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed self-checking bench for edge_detect_multi (defaults, COUNT_W = 2).
module tb_edge_detect_multi;

  logic       clk;
  logic       rst;
  logic [3:0] d_in;
  logic [7:0] mode;
  logic [3:0] clr_flags;
  logic [3:0] d_level;
  logic [3:0] d_edge;
  logic [3:0] edge_flag;
  logic       any_edge;
  logic [7:0] edge_count;

  int n_checks = 0;
  int n_fail   = 0;

  edge_detect_multi #(.COUNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .d_in       (d_in),
    .mode       (mode),
    .clr_flags  (clr_flags),
    .d_level    (d_level),
    .d_edge     (d_edge),
    .edge_flag  (edge_flag),
    .any_edge   (any_edge),
    .edge_count (edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] cnt_exp(input logic [7:0] v);
`ifdef EDGE_DETECT_COUNT_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  initial begin
    rst       = 1'b1;
    d_in      = 4'b1111;
    mode      = 8'hFF;
    clr_flags = 4'b0000;
    step(2);
    check_eq("rst_level", d_level, 4'b1111);
    check_eq("rst_edge", d_edge, 4'b0000);
    check_eq("rst_flag", edge_flag, 4'b0000);
    check_eq("rst_any", any_edge, 1'b0);
    check_eq("rst_count", edge_count, 8'h00);
    rst = 1'b0;
    step(4);
    check_eq("idle_edge", d_edge, 4'b0000);

    // 1: falling edge on ch0, all modes both
    d_in[0] = 1'b0;
    step(3);
    check_eq("t1_pre_edge", d_edge, 4'b0000);
    check_eq("t1_pre_level", d_level, 4'b1111);
    step(1);
    check_eq("t1_edge", d_edge, 4'b0001);
    check_eq("t1_any", any_edge, 1'b1);
    check_eq("t1_flag", edge_flag, 4'b0001);
    check_eq("t1_level", d_level, 4'b1110);
    check_eq("t1_count", edge_count, cnt_exp(8'h01));
    step(1);
    check_eq("t1_edge_off", d_edge, 4'b0000);
    check_eq("t1_any_off", any_edge, 1'b0);
    check_eq("t1_flag_hold", edge_flag, 4'b0001);

    // 2: ch0 rising-only
    clr_flags = 4'b0001;
    step(1);
    clr_flags = 4'b0000;
    check_eq("t2_clr_flag", edge_flag, 4'b0000);
    check_eq("t2_clr_count", edge_count, 8'h00);
    mode    = 8'hFD;
    d_in[0] = 1'b1;
    step(4);
    check_eq("t2_rise_edge", d_edge, 4'b0001);
    check_eq("t2_rise_level", d_level, 4'b1111);
    step(1);
    d_in[0] = 1'b0;
    step(4);
    check_eq("t2_fall_edge", d_edge, 4'b0000);
    check_eq("t2_fall_any", any_edge, 1'b0);
    check_eq("t2_fall_level", d_level, 4'b1110);
    step(1);
    d_in[0] = 1'b1;
    step(4);
    check_eq("t2_rise2_edge", d_edge, 4'b0001);
    check_eq("t2_rise2_level", d_level, 4'b1111);
    step(1);

    // 3: glitch rejection on ch1, then a 2-cycle low pulse
    d_in[1] = 1'b0;
    step(1);
    d_in[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      check_eq("t3_glitch_edge", d_edge, 4'b0000);
    end
    check_eq("t3_glitch_level", d_level, 4'b1111);
    check_eq("t3_glitch_flag1", edge_flag[1], 1'b0);
    d_in[1] = 1'b0;
    step(2);
    d_in[1] = 1'b1;
    step(2);
    check_eq("t3_fall_edge", d_edge, 4'b0010);
    check_eq("t3_fall_level", d_level, 4'b1101);
    step(1);
    check_eq("t3_gap_edge", d_edge, 4'b0000);
    step(1);
    check_eq("t3_rise_edge", d_edge, 4'b0010);
    check_eq("t3_rise_level", d_level, 4'b1111);
    step(1);

    // 4: set beats clear on ch2
    d_in[2] = 1'b0;
    step(3);
    clr_flags = 4'b0100;
    step(1);
    check_eq("t4_edge", d_edge, 4'b0100);
    check_eq("t4_flag_set_wins", edge_flag[2], 1'b1);
    check_eq("t4_count_inc_clr", edge_count, cnt_exp(8'h1A));
    step(1);
    clr_flags = 4'b0000;
    check_eq("t4_flag_clr", edge_flag[2], 1'b0);
    check_eq("t4_count_clr", edge_count, cnt_exp(8'h0A));
    check_eq("t4_edge_off", d_edge, 4'b0000);

    // 5: reset in the middle of a ch3 filter count
    d_in[3] = 1'b0;
    step(3);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_level", d_level, 4'b1111);
    check_eq("t5_rst_flag", edge_flag, 4'b0000);
    check_eq("t5_rst_count", edge_count, 8'h00);
    check_eq("t5_rst_edge", d_edge, 4'b0000);
    step(2);
    check_eq("t5_rst_hold_level", d_level, 4'b1111);
    rst = 1'b0;
    step(3);
    check_eq("t5_pre_edge", d_edge, 4'b0000);
    check_eq("t5_pre_level", d_level, 4'b1111);
    step(1);
    check_eq("t5_edge", d_edge, 4'b1100);
    check_eq("t5_any", any_edge, 1'b1);
    check_eq("t5_level", d_level, 4'b0011);
    check_eq("t5_flag", edge_flag, 4'b1100);
    check_eq("t5_count", edge_count, cnt_exp(8'h50));
    step(1);
    check_eq("t5_edge_off", d_edge, 4'b0000);

    // 6: saturating count on ch0
    mode = 8'hFF;
    clr_flags = 4'b0001;
    step(1);
    clr_flags = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      d_in[0] = ~d_in[0];
      step(4);
      check_eq("t6_edge", d_edge, 4'b0001);
      check_eq("t6_count0", edge_count[1:0], cnt_exp((k < 3) ? 8'(k + 1) : 8'd3));
      step(1);
    end
    check_eq("t6_sat_full", edge_count, cnt_exp(8'h53));
    clr_flags = 4'b0001;
    step(1);
    clr_flags = 4'b0000;
    check_eq("t6_clr_full", edge_count, cnt_exp(8'h50));
    check_eq("t6_clr_flag", edge_flag, 4'b1100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
Parametrised, multi-channel successor to the single-line USB edge detector. Each channel has its own synchroniser and glitch filter, and a per-channel mode selects which edges are reported: rising, falling, both, or none. Each channel produces a one-cycle edge pulse and a sticky flag. Sits between raw pins (e.g. d_plus/d_minus) and the receive decoder/timer logic.

Parameters:
NUM_CH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILTER_LEN, 2, consecutive cycles a new synchronised level must persist before acceptance (>=1)
RESET_LEVEL, 1, filtered/synchroniser level loaded at reset (USB idle high)
COUNT_W, 8, width of per-channel edge counter (optional feature only)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
d_in  input  NUM_CH  raw asynchronous inputs, bit i = channel i
mode  input  2*NUM_CH  channel i at [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
clr_flags  input  NUM_CH  per-channel synchronous clear of edge_flag
d_level  output  NUM_CH  filtered level per channel
d_edge  output  NUM_CH  one-cycle pulse per accepted, enabled edge
edge_flag  output  NUM_CH  sticky edge-seen flag per channel
any_edge  output  1  OR of d_edge, registered alongside it
edge_count  output  NUM_CH*COUNT_W  per-channel edge counters, channel i at [(i+1)*COUNT_W-1 : i*COUNT_W]

Behaviour:
- Reset (async assert, sync use after release):
  - All synchroniser flops and d_level = RESET_LEVEL.
  - Filter counters, d_edge, edge_flag, any_edge and edge_count = 0.
  - Reset mid-operation aborts any in-progress filter count; no pulse is produced for it.
- Synchroniser: s[i] is d_in[i] delayed by SYNC_STAGES flops.
- Filter, per channel, counter width clog2(FILTER_LEN+1):
  - If s == d_level: counter <= 0.
  - Otherwise counter increments. On the edge where it would reach FILTER_LEN: d_level toggles and counter <= 0.
  - Any return of s to d_level before then resets the counter, so glitches shorter than FILTER_LEN cycles are rejected.
- Latency: if d_in changes before posedge 1, d_level toggles at posedge SYNC_STAGES+FILTER_LEN. Defaults give posedge 4.
- Edge pulse: at the same edge d_level toggles, d_edge[i] <= 1 when enabled by the mode sampled at that edge:
  - 0->1 requires mode bit0.
  - 1->0 requires mode bit1.
  - Otherwise d_edge[i] <= 0.
  - d_edge is high for exactly one cycle. Back-to-back pulses need at least FILTER_LEN cycles between toggles.
- Mode 00: d_level still tracks the input; no d_edge, no flag, no count.
- Mode changes take effect at the next edge with no other side effect.
- edge_flag[i]:
  - Set when d_edge[i] is set.
  - Cleared by clr_flags[i].
  - Set and clear in the same cycle: set wins (flag stays 1).
- any_edge = registered OR of the next-state d_edge bits, so it is cycle-aligned with d_edge.
- After reset, if d_in differs from RESET_LEVEL, a genuine edge is reported after normal latency when the mode enables that direction.
- Channels are fully independent. Simultaneous edges on several channels all pulse in the same cycle.

Optional Feature:
Macro EDGE_DETECT_COUNT_EN.
- Defined: edge_count slice i increments when d_edge[i] is set and saturates at 2^COUNT_W-1 (no wrap).
  - clr_flags[i] also zeroes slice i.
  - Increment and clear in the same cycle: result = 1.
- Not defined: no counter logic is built; edge_count is tied to 0.

Test Plan:
1. Defaults, rst pulse, all modes 11, d_in=4'b1111, then d_in[0] 1->0 at negedge -> d_edge=4'b0001 for exactly one cycle at the 4th posedge; edge_flag[0]=1; d_level=4'b1110; any_edge=1 in the same cycle.
2. Mode ch0=01 (rising only): d_in[0] 1->0 -> no pulse, d_level[0]=0. Then 0->1 -> pulse at the 4th posedge.
3. Glitch rejection: d_in[1] low for 1 cycle, then back high -> d_level[1] stays 1, no d_edge, edge_flag[1]=0. A 2-cycle low pulse -> a falling pulse, then a rising pulse 2 cycles later.
4. Flag priority: clr_flags[2]=1 in the same cycle d_edge[2] is set -> edge_flag[2]=1. clr_flags[2]=1 alone next cycle -> edge_flag[2]=0.
5. Reset mid-filter: start a falling transition on ch3, assert rst after 3 cycles -> all outputs 0, d_level=4'b1111. Release with d_in[3]=0 -> falling pulse 4 cycles after the first post-reset posedge.
6. With EDGE_DETECT_COUNT_EN and COUNT_W=2: 5 edges on ch0 -> edge_count[1:0]=3 (saturated). Then clr_flags[0] -> 0.
